// File: rtl/mul_norm_pipe.sv
// Two-stage post-multiply normaliser: S1 corrects the anticipated leading-zero count,
// S2 shifts the mantissa, adjusts the exponent and flags overflow/underflow/zero.
module mul_norm_pipe #(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  localparam int W  = 2*MANT_W + 2,
  localparam int CW = $clog2(W + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_mant,
  input  logic [EXPO_W+1:0]   in_expo,
  input  logic [CW-1:0]       in_cnt_uc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MANT_W:0]     out_mant,
  output logic                out_guard,
  output logic                out_sticky,
  output logic [EXPO_W+1:0]   out_expo,
  output logic [CW-1:0]       out_cnt,
  output logic                out_revised,
  output logic                out_zero,
  output logic                out_ovf,
  output logic                out_unf,
  input  logic                clr_stat,
  output logic [15:0]         rev_cnt
);

  localparam int EW = EXPO_W + 2;
  localparam logic [CW-1:0] W_CNT   = CW'(W);
  localparam logic [EW-1:0] OVF_LIM = EW'((1 << EXPO_W) - 1);

  logic            s1_valid_q, s1_valid_d;
  logic [W-1:0]    s1_mant_q, s1_mant_d;
  logic [EW-1:0]   s1_expo_q, s1_expo_d;
  logic [CW-1:0]   s1_cnt_q, s1_cnt_d;
  logic            s1_rev_q, s1_rev_d;

  logic            out_valid_q, out_valid_d;
  logic [MANT_W:0] out_mant_q, out_mant_d;
  logic            out_guard_q, out_guard_d;
  logic            out_sticky_q, out_sticky_d;
  logic [EW-1:0]   out_expo_q, out_expo_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic            out_revised_q, out_revised_d;
  logic            out_zero_q, out_zero_d;
  logic            out_ovf_q, out_ovf_d;
  logic            out_unf_q, out_unf_d;
  logic [15:0]     rev_cnt_q, rev_cnt_d;

  logic            s2_ready;
  logic            s1_moves;
  logic [CW-1:0]   cnt_clamp;
  logic [W-1:0]    probe;
  logic            revise;
  logic [W-1:0]    norm;
  logic [EW-1:0]   expo_adj;
  logic            mant_zero;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_moves = s1_valid_q && s2_ready;
  assign in_ready = !s1_valid_q || s1_moves;

  // Shifting by cnt-1 brings the probed bit W-cnt up to the MSB.
  always_comb begin
    cnt_clamp = (in_cnt_uc > W_CNT) ? W_CNT : in_cnt_uc;
    probe     = in_mant << (cnt_clamp - CW'(1));
    revise    = (cnt_clamp != '0) && probe[W-1];

    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_expo_d  = s1_expo_q;
    s1_cnt_d   = s1_cnt_q;
    s1_rev_d   = s1_rev_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_valid && in_ready) begin
      s1_mant_d = in_mant;
      s1_expo_d = in_expo;
      s1_cnt_d  = revise ? cnt_clamp - CW'(1) : cnt_clamp;
      s1_rev_d  = revise;
    end
  end

  always_comb begin
    norm      = s1_mant_q << s1_cnt_q;
    expo_adj  = s1_expo_q + EW'(1) - EW'(s1_cnt_q);
    mant_zero = (s1_mant_q == '0);

    out_valid_d   = out_valid_q;
    out_mant_d    = out_mant_q;
    out_guard_d   = out_guard_q;
    out_sticky_d  = out_sticky_q;
    out_expo_d    = out_expo_q;
    out_cnt_d     = out_cnt_q;
    out_revised_d = out_revised_q;
    out_zero_d    = out_zero_q;
    out_ovf_d     = out_ovf_q;
    out_unf_d     = out_unf_q;
    if (s2_ready) out_valid_d = s1_valid_q;
    if (s1_moves) begin
      if (mant_zero) begin
        out_mant_d    = '0;
        out_guard_d   = 1'b0;
        out_sticky_d  = 1'b0;
        out_expo_d    = '0;
        out_cnt_d     = '0;
        out_revised_d = 1'b0;
        out_zero_d    = 1'b1;
        out_ovf_d     = 1'b0;
        out_unf_d     = 1'b0;
      end else begin
        out_mant_d    = norm[W-1:MANT_W+1];
        out_guard_d   = norm[MANT_W];
        out_sticky_d  = |norm[MANT_W-1:0];
        out_expo_d    = expo_adj;
        out_cnt_d     = s1_cnt_q;
        out_revised_d = s1_rev_q;
        out_zero_d    = 1'b0;
        out_ovf_d     = $signed(expo_adj) >= $signed(OVF_LIM);
        out_unf_d     = expo_adj[EW-1] || (expo_adj == '0);
      end
    end
  end

  // Clear wins over a same-cycle revised transfer; the counter sticks at all-ones.
  always_comb begin
    rev_cnt_d = rev_cnt_q;
    if (clr_stat)
      rev_cnt_d = '0;
    else if (out_valid_q && out_ready && out_revised_q && (rev_cnt_q != 16'hFFFF))
      rev_cnt_d = rev_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_mant_q     <= '0;
      s1_expo_q     <= '0;
      s1_cnt_q      <= '0;
      s1_rev_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_mant_q    <= '0;
      out_guard_q   <= 1'b0;
      out_sticky_q  <= 1'b0;
      out_expo_q    <= '0;
      out_cnt_q     <= '0;
      out_revised_q <= 1'b0;
      out_zero_q    <= 1'b0;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
      rev_cnt_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_mant_q     <= s1_mant_d;
      s1_expo_q     <= s1_expo_d;
      s1_cnt_q      <= s1_cnt_d;
      s1_rev_q      <= s1_rev_d;
      out_valid_q   <= out_valid_d;
      out_mant_q    <= out_mant_d;
      out_guard_q   <= out_guard_d;
      out_sticky_q  <= out_sticky_d;
      out_expo_q    <= out_expo_d;
      out_cnt_q     <= out_cnt_d;
      out_revised_q <= out_revised_d;
      out_zero_q    <= out_zero_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
      rev_cnt_q     <= rev_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_mant    = out_mant_q;
  assign out_guard   = out_guard_q;
  assign out_sticky  = out_sticky_q;
  assign out_expo    = out_expo_q;
  assign out_cnt     = out_cnt_q;
  assign out_revised = out_revised_q;
  assign out_zero    = out_zero_q;
  assign out_ovf     = out_ovf_q;
  assign out_unf     = out_unf_q;
  assign rev_cnt     = rev_cnt_q;

endmodule

// File: doc/mul_norm_pipe.md
MUL_NORM_PIPE -- requirements
Module: mul_norm_pipe

Interface
REQ-001 SHALL have parameter EXPO_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MANT_W, default 23, meaning stored mantissa width; W = 2*MANT_W+2 is product width; CW = $clog2(W+1) is count width.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input transaction valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_mant  input  W  unnormalised product mantissa.
REQ-008 SHALL have port in_expo  input  EXPO_W+2  signed biased exponent sum.
REQ-009 SHALL have port in_cnt_uc  input  CW  anticipated leading-zero count, exact or one too high.
REQ-010 SHALL have port out_valid  output  1  output transaction valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts output.
REQ-012 SHALL have port out_mant  output  MANT_W+1  normalised mantissa, hidden bit at MSB.
REQ-013 SHALL have port out_guard / out_sticky  output  1 each  rounding bits.
REQ-014 SHALL have port out_expo  output  EXPO_W+2  signed adjusted exponent.
REQ-015 SHALL have port out_cnt  output  CW  corrected zero count.
REQ-016 SHALL have port out_revised / out_zero / out_ovf / out_unf  output  1 each  status flags.
REQ-017 SHALL have port clr_stat  input  1  clear statistics counter.
REQ-018 SHALL have port rev_cnt  output  16  count of revised results delivered.

Function
REQ-019 SHALL be a 2-stage pipeline: S1 correction, S2 shift/exponent; latency 2 cycles with out_ready high; throughput 1/cycle.
REQ-020 SHALL transfer a transaction on valid&ready; each stage loads when empty or when its content moves on the same cycle; in_ready = !s1_valid | s1_moves.
REQ-021 SHALL hold out_valid and all out_* stable while out_valid&!out_ready; no transaction is dropped or duplicated; order is preserved.
REQ-022 SHALL clamp in_cnt_uc values greater than W to W before use.
REQ-023 SHALL set revise = 1 when cnt_uc>0 and in_mant[W-cnt_uc]==1; cnt_c = cnt_uc-1 if revise, else cnt_uc.
REQ-024 SHALL compute norm = in_mant << cnt_c (W bits); out_mant = norm[W-1:MANT_W+1]; out_guard = norm[MANT_W]; out_sticky = |norm[MANT_W-1:0].
REQ-025 SHALL compute out_expo = in_expo + 1 - cnt_c in EXPO_W+2-bit signed arithmetic.
REQ-026 SHALL set out_ovf when out_expo >= 2^EXPO_W-1, and out_unf when out_expo <= 0.
REQ-027 SHALL, when in_mant==0, force out_zero=1 and out_mant, guard, sticky, expo, cnt, revised, ovf and unf to 0.
REQ-028 SHALL increment rev_cnt by 1 on each output transfer with out_revised=1, saturating at 16'hFFFF.
REQ-029 SHALL give clr_stat priority over increment when both occur in the same cycle, so rev_cnt becomes 0.

Reset
REQ-030 SHALL, while rst_n is low at a clk edge, clear both stage valids and rev_cnt, forcing out_valid=0 and rev_cnt=0 on the next cycle.
REQ-031 SHALL reset all out_* data registers to 0, with in_ready=1 from the first cycle after reset.
REQ-032 SHALL discard in-flight transactions on a mid-operation reset, with no output produced for them.

Verification (MANT_W=23, EXPO_W=8, W=48)
REQ-033 SHALL cover: mant=48'h8000_0000_0000, cnt_uc=0, expo=127 -> 2 cycles later out_mant=24'h800000, cnt=0, expo=128, revised=0.
REQ-034 SHALL cover: mant=48'h4000_0000_0000, cnt_uc=2, expo=127 -> revised=1, cnt=1, out_mant=24'h800000, expo=127, rev_cnt=1.
REQ-035 SHALL cover: mant=0, any cnt_uc and expo -> out_zero=1, all other outputs 0.
REQ-036 SHALL cover: out_ready low 5 cycles while 3 back-to-back inputs are offered -> in_ready low after 2 accepted, 3 outputs in order, out_* stable while stalled.
REQ-037 SHALL cover: bit47 set, cnt_uc=0, expo=254 -> expo=255, ovf=1; bit46 set, cnt_uc=1, expo=0 -> revised=0, cnt=1, expo=0, unf=1.
REQ-038 SHALL cover: rst_n low 1 cycle with both stages full and rev_cnt=5 -> out_valid=0 and rev_cnt=0 next cycle; clr_stat with a revised transfer in the same cycle -> rev_cnt=0.
